// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 5..9 data bits, none/odd/even parity, 1-2 stop bits,
// 3-sample majority voting, error flags and a valid/ack output handshake.
module uart_rx_param #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int UART_BAUD  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 uart_rx_path,
  input  logic                 uart_rx_ack,
  output logic [DATA_BITS-1:0] uart_rx_data,
  output logic                 uart_rx_valid,
  output logic                 uart_rx_done,
  output logic                 uart_rx_parity_err,
  output logic                 uart_rx_frame_err,
  output logic                 uart_rx_break,
  output logic                 uart_rx_overrun,
  output logic                 uart_rx_busy
);
  localparam int DIV = CLOCK_FREQ / UART_BAUD;
  localparam int TW  = $clog2(DIV);
  localparam int BW  = $clog2(10);
  localparam logic [TW-1:0] T_S0   = TW'(DIV/2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(DIV/2);
  localparam logic [TW-1:0] T_VOTE = TW'(DIV/2 + 1);
  localparam logic [TW-1:0] T_END  = TW'(DIV - 1);
  localparam logic [BW-1:0] B_DLAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_SLAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PAR = 3'd3, STOP = 3'd4, WAIT_HIGH = 3'd5
  } state_t;

  function automatic logic parity_err(input logic [DATA_BITS-1:0] d, input logic p);
    logic x;
    x = ^{d, p};
    case (PARITY)
      1:       return ~x;
      2:       return x;
      default: return 1'b0;
    endcase
  endfunction

  logic       s1_q, s2_q, prev_q;
  logic [1:0] fill_q;
  logic       rxs, fall_s;

  // prev_q stays 0 until the synchronizer holds real line samples, so a line
  // that is low at reset release is not mistaken for a start edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      fill_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= uart_rx_path;
      s2_q   <= s1_q;
      fill_q <= {fill_q[0], 1'b1};
      prev_q <= fill_q[1] & s2_q;
    end
  end

  assign rxs    = s2_q;
  assign fall_s = prev_q & ~rxs;

  state_t               state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic [1:0]           v_q, v_d;
  logic par_q, par_d, fe_q, fe_d;
  logic valid_q, valid_d, done_q, done_d, perr_q, perr_d, ferr_q, ferr_d;
  logic brk_q, brk_d, ovr_q, ovr_d, busy_q, busy_d;
  logic vote_s, at_vote_s, at_end_s, complete_s, fe_now_s;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      v_q     <= 2'b00;
      par_q   <= 1'b0;
      fe_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      v_q     <= v_d;
      par_q   <= par_d;
      fe_q    <= fe_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign vote_s    = (v_q[0] & v_q[1]) | (v_q[0] & rxs) | (v_q[1] & rxs);
  assign at_vote_s = (tcnt_q == T_VOTE);
  assign at_end_s  = (tcnt_q == T_END);
  assign fe_now_s  = fe_q | ~vote_s;

  always_comb begin
    state_d    = state_q;
    tcnt_d     = at_end_s ? '0 : tcnt_q + TW'(1);
    bcnt_d     = bcnt_q;
    sh_d       = sh_q;
    par_d      = par_q;
    fe_d       = fe_q;
    v_d        = v_q;
    complete_s = 1'b0;
    if (tcnt_q == T_S0)      v_d[0] = rxs;
    else if (tcnt_q == T_S1) v_d[1] = rxs;
    else                     v_d    = v_q;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (fall_s) state_d = START;
        else        state_d = IDLE;
      end
      START: begin
        if (at_vote_s && vote_s) begin
          state_d = IDLE;
        end else if (at_end_s) begin
          state_d = DATA;
          bcnt_d  = '0;
          fe_d    = 1'b0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (at_vote_s) sh_d = {vote_s, sh_q[DATA_BITS-1:1]};
        else           sh_d = sh_q;
        if (at_end_s) begin
          if (bcnt_q == B_DLAST) begin
            bcnt_d  = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end else begin
            bcnt_d  = bcnt_q + BW'(1);
          end
        end else begin
          bcnt_d = bcnt_q;
        end
      end
      PAR: begin
        if (at_vote_s) par_d = vote_s;
        else           par_d = par_q;
        if (at_end_s) begin
          state_d = STOP;
          bcnt_d  = '0;
        end else begin
          state_d = PAR;
        end
      end
      STOP: begin
        // The frame completes at the last stop-bit vote, half a bit early.
        if (at_vote_s) begin
          fe_d = fe_now_s;
          if (bcnt_q == B_SLAST) begin
            complete_s = 1'b1;
            state_d    = vote_s ? IDLE : WAIT_HIGH;
          end else begin
            state_d    = STOP;
          end
        end else if (at_end_s) begin
          bcnt_d = bcnt_q + BW'(1);
        end else begin
          bcnt_d = bcnt_q;
        end
      end
      WAIT_HIGH: begin
        tcnt_d = '0;
        if (rxs) state_d = IDLE;
        else     state_d = WAIT_HIGH;
      end
      default: begin
        state_d = IDLE;
        tcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    brk_d   = brk_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    done_d  = complete_s;
    busy_d  = (state_d != IDLE);
    if (complete_s) begin
      data_d  = sh_q;
      perr_d  = parity_err(sh_q, par_q);
      ferr_d  = fe_now_s;
      brk_d   = (sh_q == '0) && ((PARITY == 0) || !par_q) && fe_now_s;
      valid_d = 1'b1;
      ovr_d   = valid_q & ~uart_rx_ack;
    end else if (valid_q && uart_rx_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  assign uart_rx_data       = data_q;
  assign uart_rx_valid      = valid_q;
  assign uart_rx_done       = done_q;
  assign uart_rx_parity_err = perr_q;
  assign uart_rx_frame_err  = ferr_q;
  assign uart_rx_break      = brk_q;
  assign uart_rx_overrun    = ovr_q;
  assign uart_rx_busy       = busy_q;
endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: the next generation of the single-format 8N1 receiver. It supports 5–9 data bits, none/odd/even parity and 1 or 2 stop bits. It adds start-bit validation, 3-sample majority voting, error flags (parity, framing, break, overrun) and a valid/ack output handshake. It sits between the board's RX pin and any byte consumer (command parser, FIFO) in the `clk_in` domain.

## Interface
Parameters:
- `CLOCK_FREQ`, 50_000_000: `clk_in` frequency in Hz.
- `UART_BAUD`, 115200: line rate. `DIV = CLOCK_FREQ / UART_BAUD` (integer). `DIV >= 8` is required.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clk_in`, in, 1: single system clock, rising edge.
- `rst_in`, in, 1: asynchronous, active-high reset.
- `uart_rx_path`, in, 1: serial line, idle high, asynchronous to `clk_in`.
- `uart_rx_ack`, in, 1: consumer accepts the held word.
- `uart_rx_data`, out, `DATA_BITS`: received word, LSB first on the line.
- `uart_rx_valid`, out, 1: word held. Stays high until acked.
- `uart_rx_done`, out, 1: one-cycle pulse at each frame completion.
- `uart_rx_parity_err`, out, 1: parity mismatch for the held word.
- `uart_rx_frame_err`, out, 1: a stop bit was sampled low.
- `uart_rx_break`, out, 1: break detected (all-zero frame including stop).
- `uart_rx_overrun`, out, 1: sticky. A frame completed while `uart_rx_valid` was high.
- `uart_rx_busy`, out, 1: state is not IDLE.

## Operation
- Input passes through a 2-flop synchronizer; reset value 1. All logic uses the synchronized `rxs`.
- Bit timer `tcnt` counts 0..DIV-1. Majority vote takes samples at `tcnt = DIV/2-1`, `DIV/2` and `DIV/2+1`. Bit value = majority, resolved at `DIV/2+1`.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: a falling edge on `rxs` (previous 1, current 0) clears `tcnt` and moves to START.
  - START: the voted bit must be 0, then at `tcnt = DIV-1` go to DATA. A voted 1 is a false start: return to IDLE with no outputs.
  - DATA: shift `DATA_BITS` voted bits LSB first into a shift register. Bit counter width is ceil(log2(10)).
  - PARITY: entered only if `PARITY != 0`. Store the voted bit.
  - STOP: `STOP_BITS` stop bits. Each is voted; any 0 sets the local frame error.
    - Completion happens at the vote of the last stop bit, not at end of bit. This leaves half a bit of margin for the next start edge.
    - Completion goes to IDLE if the voted stop is 1, otherwise to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs` = 1, then IDLE. No new frame can start until then.
- Parity check: odd means XOR(data, parity bit) must be 1; even means it must be 0.
- On completion:
  - Load `uart_rx_data`, `uart_rx_parity_err`, `uart_rx_frame_err` and `uart_rx_break`.
  - Break = data all zero, parity bit 0 (if present) and frame error.
  - Set `uart_rx_valid` and pulse `uart_rx_done`.
  - If `uart_rx_valid` was already high and not being acked in the same cycle, set `uart_rx_overrun`. The new word still overwrites the old one.
- `uart_rx_ack` while valid clears `uart_rx_valid` and `uart_rx_overrun` next cycle.
  - Ack while not valid has no effect.
  - Ack in the same cycle as completion: the new word is loaded, valid stays 1, no overrun.
- Error flags update only on completion. They are held with the word.

## Timing
- Reset values:
  - Outputs: all 0; `uart_rx_data` = 0.
  - Internals: FSM = IDLE, `tcnt` = 0, synchronizer = 1.
- Asserting `rst_in` mid-frame aborts immediately. After release the receiver waits for a fresh falling edge. A line held low at release is not treated as a start until it goes high then low.
- Edge-to-`rxs` latency: 2 cycles.
- Completion (done, valid, data) is registered 1 cycle after the final stop-bit vote cycle. That is about (1 + DATA_BITS + P + STOP_BITS − 0.5) × DIV + 3 cycles after the line falling edge, where P = 1 with parity and 0 without.
- `uart_rx_done` is high for exactly 1 cycle per completed frame. There is no pulse for false starts.
- `uart_rx_busy` is high from the cycle after edge detection until the cycle FSM returns to IDLE, WAIT_HIGH included.

## Test plan
- 8N1, DIV = 434: send 0xA5 then 0x3C back-to-back, ack each on valid → two done pulses, data 0xA5 then 0x3C, all error flags 0.
- 7E2 (DATA_BITS = 7, PARITY = 2, STOP_BITS = 2): send 0x41 with parity bit 0 → data 0x41, parity_err 0. Resend with parity bit forced 1 → parity_err 1.
- Glitch: 100-cycle low pulse on an idle line → no done pulse, busy returns to 0 before DIV cycles. A single-cycle 0 spike at mid-bit of data 0xFF → data 0xFF (majority rejects it).
- Break: hold line low for 12 bit times → data 0, frame_err 1, break 1, busy stays 1 until the line rises. The next 0x55 frame is received cleanly.
- Overrun: send 0x11 then 0x22 with no ack → data 0x22, overrun 1. Ack → valid 0, overrun 0. Ack coincident with completion → no overrun.
- Reset at mid-DATA of a frame, released while the line is still low → no done pulse. The next full frame 0x96 is received correctly.
